pwm_ramp: RTL and testbench

Duty-cycle ramp sequencer placed directly upstream of the PWM generator. It accepts a period/target/step/divider command via valid/ready and drives the generator's `wave_length` and `high_time` inputs. It moves `high_time` toward the target in saturating steps, one step every `div+1` PWM periods. All output changes are aligned to the generator's period boundary, signalled by its `last_cycle` output.

---
 rtl/pwm_pkg.sv | 18 +
 rtl/pwm_ramp_step.sv | 47 ++++
 rtl/pwm_ramp.sv | 137 +++++++++++++
 tb/tb_pwm_ramp.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg
// Definitions shared by the duty-cycle ramp sequencer and the PWM generator it
// feeds: default data widths and the sequencer state encoding.
package pwm_pkg;

  // Default widths, kept identical to the generator's so that wave_length and
  // high_time connect without resizing.
  localparam int PWM_WIDTH     = 16;
  localparam int PWM_DIV_WIDTH = 8;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RAMP = 2'd2
  } ramp_state_e;

endpackage

// File: rtl/pwm_ramp_step.sv
// pwm_ramp_step
// Combinational saturating step: moves cur_i toward target_i by at most step_i
// and never past target_i. A step of 0 jumps straight to the target.
// Ports:
//   cur_i    current high_time
//   target_i final high_time
//   step_i   maximum change per step (0 = jump)
//   next_o   high_time after this step
//   hit_o    next_o equals target_i
module pwm_ramp_step
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH
) (
  input  logic [WIDTH-1:0] cur_i,
  input  logic [WIDTH-1:0] target_i,
  input  logic [WIDTH-1:0] step_i,
  output logic [WIDTH-1:0] next_o,
  output logic             hit_o
);

  // diff is target - cur in WIDTH+1 bits; its top bit is the sign, so the
  // magnitude always fits and the compare against step cannot wrap.
  logic [WIDTH:0] diff;
  logic           diff_neg;
  logic [WIDTH:0] diff_mag;

  always_comb begin
    diff     = {1'b0, target_i} - {1'b0, cur_i};
    diff_neg = diff[WIDTH];
    diff_mag = diff_neg ? (~diff + {{WIDTH{1'b0}}, 1'b1}) : diff;
    next_o   = cur_i;
    if (diff == '0) begin
      next_o = cur_i;
    end else if ((step_i == '0) || (diff_mag <= {1'b0, step_i})) begin
      next_o = target_i;
    end else if (diff_neg) begin
      // |diff| > step here, so cur - step stays above target.
      next_o = cur_i - step_i;
    end else begin
      // |diff| > step here, so cur + step stays below target.
      next_o = cur_i + step_i;
    end
    hit_o = (next_o == target_i);
  end

endmodule

// File: rtl/pwm_ramp.sv
// pwm_ramp
// Duty-cycle ramp sequencer sitting in front of the PWM generator. Accepts a
// period/target/step/divider command, then walks high_time toward the target
// one saturating step every div+1 PWM periods. Every output change happens in
// the cycle after a rising edge of the generator's last_cycle.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   cmd_valid / cmd_ready     command handshake
//   cmd_period, cmd_target,
//   cmd_step, cmd_div         command payload
//   last_cycle                period-boundary indication from the generator
//   wave_length, high_time    registered settings for the generator
//   busy                      in ARM or RAMP
//   done                      one-cycle pulse with the final high_time
//   dbg_state                 current state (pwm_pkg::ramp_state_e encoding)
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only in IDLE, depends on state
// alone (never on cmd_valid), and drops in the cycle after a transfer; the
// payload is sampled only on that edge and need not be held afterwards.
module pwm_ramp
  import pwm_pkg::*;
#(
  parameter int WIDTH     = PWM_WIDTH,
  parameter int DIV_WIDTH = PWM_DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [WIDTH-1:0]     cmd_period,
  input  logic [WIDTH-1:0]     cmd_target,
  input  logic [WIDTH-1:0]     cmd_step,
  input  logic [DIV_WIDTH-1:0] cmd_div,
  input  logic                 last_cycle,
  output logic [WIDTH-1:0]     wave_length,
  output logic [WIDTH-1:0]     high_time,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           dbg_state
);

  ramp_state_e          state_q;
  logic                 last_cycle_q;
  logic [WIDTH-1:0]     period_q;
  logic [WIDTH-1:0]     target_q;
  logic [WIDTH-1:0]     step_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] div_cnt_q;
  logic [WIDTH-1:0]     wave_length_q;
  logic [WIDTH-1:0]     high_time_q;
  logic                 done_q;

  logic                 bnd;
  logic [WIDTH-1:0]     high_time_d;
  logic                 step_hit;

  // A level held high counts once: only the low-to-high transition is a boundary.
  assign bnd = last_cycle & ~last_cycle_q;

  pwm_ramp_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .cur_i    (high_time_q),
    .target_i (target_q),
    .step_i   (step_q),
    .next_o   (high_time_d),
    .hit_o    (step_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      last_cycle_q  <= 1'b0;
      period_q      <= '0;
      target_q      <= '0;
      step_q        <= '0;
      div_q         <= '0;
      div_cnt_q     <= '0;
      wave_length_q <= '1;
      high_time_q   <= '0;
      done_q        <= 1'b0;
    end else begin
      last_cycle_q <= last_cycle;
      done_q       <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Any boundary seen here, including one on the acceptance edge,
          // is deliberately ignored; ARM waits for the next one.
          if (cmd_valid) begin
            period_q <= cmd_period;
            target_q <= cmd_target;
            step_q   <= cmd_step;
            div_q    <= cmd_div;
            state_q  <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (bnd) begin
            wave_length_q <= period_q;
            high_time_q   <= high_time_d;
            div_cnt_q     <= div_q;
            if (step_hit) begin
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_RAMP;
            end
          end
        end
        ST_RAMP: begin
          if (bnd) begin
            if (div_cnt_q != '0) begin
              div_cnt_q <= div_cnt_q - DIV_WIDTH'(1);
            end else begin
              high_time_q <= high_time_d;
              div_cnt_q   <= div_q;
              if (step_hit) begin
                done_q  <= 1'b1;
                state_q <= ST_IDLE;
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q == ST_ARM) || (state_q == ST_RAMP);
  assign wave_length = wave_length_q;
  assign high_time   = high_time_q;
  assign done        = done_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_pwm_ramp.sv
// tb_pwm_ramp
// Directed bench for pwm_ramp. Boundaries come either from a bench-driven
// last_cycle or from a small PWM generator model fed by the DUT outputs.
module tb_pwm_ramp;
  import pwm_pkg::*;

  localparam int W  = 16;
  localparam int DW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [W-1:0]  cmd_period = '0;
  logic [W-1:0]  cmd_target = '0;
  logic [W-1:0]  cmd_step = '0;
  logic [DW-1:0] cmd_div = '0;
  logic          last_cycle;
  logic [W-1:0]  wave_length;
  logic [W-1:0]  high_time;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  pwm_ramp #(.WIDTH(W), .DIV_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_period  (cmd_period),
    .cmd_target  (cmd_target),
    .cmd_step    (cmd_step),
    .cmd_div     (cmd_div),
    .last_cycle  (last_cycle),
    .wave_length (wave_length),
    .high_time   (high_time),
    .busy        (busy),
    .done        (done),
    .dbg_state   (dbg_state)
  );

  // ---------------- generator model ----------------
  logic         use_gen = 1'b0;
  logic         man_last = 1'b0;
  logic [W-1:0] gen_cnt;
  logic         gen_last;
  logic         gen_out;
  logic         tb_lc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) gen_cnt <= '0;
    else if (gen_cnt >= wave_length) gen_cnt <= '0;
    else gen_cnt <= gen_cnt + 16'd1;
  end
  assign gen_last   = (gen_cnt == wave_length);
  assign gen_out    = (gen_cnt < high_time);
  assign last_cycle = use_gen ? gen_last : man_last;

  // Bench's own copy of last_cycle, to spot a pending boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tb_lc_q <= 1'b0;
    else tb_lc_q <= last_cycle;
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [W-1:0] p, input logic [W-1:0] t,
                          input logic [W-1:0] s, input logic [DW-1:0] d);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("cmd_ready_wait", 32'(ok), 32'd1);
    cmd_period = p;
    cmd_target = t;
    cmd_step   = s;
    cmd_div    = d;
    cmd_valid  = 1'b1;
    tick();
    cmd_valid  = 1'b0;
  endtask

  // Bench-driven boundary: low for a cycle, then high for one edge.
  // Returns #1 after the edge on which the DUT saw the boundary.
  task automatic bnd_rise();
    man_last = 1'b0;
    tick();
    man_last = 1'b1;
    tick();
    man_last = 1'b0;
  endtask

  // Wait for the next boundary from the generator, bounded.
  task automatic wait_gen_bnd(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (last_cycle && !tb_lc_q) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  logic [W-1:0] exp_down [10];
  int           low_cnt;

  initial begin
    exp_down = '{16'd6, 16'd6, 16'd6, 16'd4, 16'd4, 16'd4, 16'd2, 16'd2, 16'd2, 16'd1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_wave", 32'(wave_length), 32'hFFFF);
    check("rst_high", 32'(high_time), 32'h0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    tick();

    // Prep: period 5, target equal to current (0): done at first boundary
    send_cmd(16'd5, 16'd0, 16'd0, 8'd0);
    check("prep_ready_low", 32'(cmd_ready), 32'd0);
    check("prep_state_arm", 32'(dbg_state), 32'(ST_ARM));
    check("prep_wave_hold", 32'(wave_length), 32'hFFFF);
    bnd_rise();
    check("prep_wave", 32'(wave_length), 32'd5);
    check("prep_high", 32'(high_time), 32'd0);
    check("prep_done", 32'(done), 32'd1);
    check("prep_ready", 32'(cmd_ready), 32'd1);

    // Up-ramp with the generator connected
    use_gen = 1'b1;
    tick();
    send_cmd(16'd9, 16'd8, 16'd3, 8'd0);
    wait_gen_bnd("up_b1_seen");
    check("up_b1_high", 32'(high_time), 32'd3);
    check("up_b1_wave", 32'(wave_length), 32'd9);
    check("up_b1_done", 32'(done), 32'd0);
    check("up_b1_busy", 32'(busy), 32'd1);
    tick();
    tick();
    check("up_hold_high", 32'(high_time), 32'd3);
    wait_gen_bnd("up_b2_seen");
    check("up_b2_high", 32'(high_time), 32'd6);
    check("up_b2_done", 32'(done), 32'd0);
    wait_gen_bnd("up_b3_seen");
    check("up_b3_high", 32'(high_time), 32'd8);
    check("up_b3_done", 32'(done), 32'd1);
    check("up_b3_ready", 32'(cmd_ready), 32'd1);
    tick();
    check("up_done_1cyc", 32'(done), 32'd0);
    use_gen = 1'b0;
    tick();

    // Down-ramp with divider 2 from 8 to 1, step 2
    send_cmd(16'd9, 16'd1, 16'd2, 8'd2);
    for (int b = 0; b < 10; b++) begin
      bnd_rise();
      check($sformatf("down_b%0d_high", b + 1), 32'(high_time), 32'(exp_down[b]));
      check($sformatf("down_b%0d_done", b + 1), 32'(done), (b == 9) ? 32'd1 : 32'd0);
    end

    // Step 0 jumps to target; repeating it completes with no change
    send_cmd(16'd9, 16'd5, 16'd0, 8'd0);
    check("s0_arm_high", 32'(high_time), 32'd1);
    bnd_rise();
    check("s0_high", 32'(high_time), 32'd5);
    check("s0_done", 32'(done), 32'd1);
    send_cmd(16'd9, 16'd5, 16'd0, 8'd0);
    check("eq_arm_done", 32'(done), 32'd0);
    bnd_rise();
    check("eq_high", 32'(high_time), 32'd5);
    check("eq_done", 32'(done), 32'd1);

    // cmd_valid held high through a ramp: next acceptance only from IDLE
    send_cmd(16'd9, 16'd2, 16'd1, 8'd0);
    cmd_valid = 1'b1;
    bnd_rise();
    check("hv_b1_high", 32'(high_time), 32'd4);
    check("hv_b1_ready", 32'(cmd_ready), 32'd0);
    check("hv_b1_state", 32'(dbg_state), 32'(ST_RAMP));
    bnd_rise();
    check("hv_b2_high", 32'(high_time), 32'd3);
    check("hv_b2_state", 32'(dbg_state), 32'(ST_RAMP));
    bnd_rise();
    check("hv_b3_high", 32'(high_time), 32'd2);
    check("hv_b3_done", 32'(done), 32'd1);
    check("hv_b3_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    check("hv_reaccept_state", 32'(dbg_state), 32'(ST_ARM));
    bnd_rise();
    check("hv_reaccept_done", 32'(done), 32'd1);
    check("hv_reaccept_high", 32'(high_time), 32'd2);

    // last_cycle held high for 3 cycles counts as one boundary
    send_cmd(16'd9, 16'd6, 16'd1, 8'd0);
    man_last = 1'b0;
    tick();
    man_last = 1'b1;
    tick();
    check("lvl_first_high", 32'(high_time), 32'd3);
    tick();
    tick();
    man_last = 1'b0;
    tick();
    check("lvl_held_high", 32'(high_time), 32'd3);
    bnd_rise();
    check("lvl_next_high", 32'(high_time), 32'd4);
    bnd_rise();
    bnd_rise();
    check("lvl_end_high", 32'(high_time), 32'd6);
    check("lvl_end_done", 32'(done), 32'd1);

    // Acceptance coinciding with a boundary: applied at the following one
    man_last = 1'b0;
    tick();
    cmd_period = 16'd9;
    cmd_target = 16'd9;
    cmd_step   = 16'd0;
    cmd_div    = 8'd0;
    cmd_valid  = 1'b1;
    man_last   = 1'b1;
    tick();
    cmd_valid  = 1'b0;
    check("co_state", 32'(dbg_state), 32'(ST_ARM));
    check("co_high_hold", 32'(high_time), 32'd6);
    tick();
    check("co_high_hold2", 32'(high_time), 32'd6);
    bnd_rise();
    check("co_high", 32'(high_time), 32'd9);
    check("co_done", 32'(done), 32'd1);

    // 100% duty: high_time above the period
    send_cmd(16'd4, 16'd7, 16'd0, 8'd0);
    bnd_rise();
    check("full_wave", 32'(wave_length), 32'd4);
    check("full_high", 32'(high_time), 32'd7);
    use_gen = 1'b1;
    tick();
    tick();
    low_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (gen_out !== 1'b1) low_cnt++;
      tick();
    end
    check("full_out_low_cnt", 32'(low_cnt), 32'd0);
    use_gen = 1'b0;
    tick();

    // Asynchronous reset in the middle of a ramp
    send_cmd(16'd4, 16'd100, 16'd1, 8'd0);
    bnd_rise();
    bnd_rise();
    check("mid_high", 32'(high_time), 32'd9);
    check("mid_busy", 32'(busy), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("arst_wave", 32'(wave_length), 32'hFFFF);
    check("arst_high", 32'(high_time), 32'h0);
    check("arst_ready", 32'(cmd_ready), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_state", 32'(dbg_state), 32'(ST_IDLE));
    #2;
    rst = 1'b0;
    tick();
    bnd_rise();
    check("arst_discard_high", 32'(high_time), 32'h0);
    check("arst_discard_busy", 32'(busy), 32'd0);
    check("arst_discard_done", 32'(done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
